// File: rtl/midi_pkg.sv
// ---------------------------------------------------------------------------
// midi_pkg
// Shared definitions for the MIDI receive control path.
//   state_t         : control FSM states
//   STATUS_MIN      : first status byte value (below is a data byte)
//   SYSCOM_MIN      : first system common / exclusive byte value
//   REALTIME_MIN    : first system real-time byte value
//   TMO_W           : width of the inter-byte timeout counter
//   data_bytes_for  : number of data bytes carried by a channel message
// ---------------------------------------------------------------------------
package midi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } state_t;

    localparam logic [7:0] STATUS_MIN   = 8'h80;
    localparam logic [7:0] SYSCOM_MIN   = 8'hF0;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    localparam int TMO_W = 32;

    // Program change (C) and channel pressure (D) carry a single data byte;
    // every other channel message carries two.
    function automatic logic [1:0] data_bytes_for(input logic [3:0] hi_nibble);
        logic [1:0] n;
        n = 2'd2;
        if (hi_nibble == 4'hC || hi_nibble == 4'hD) begin
            n = 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/midi_timeout_cnt.sv
// ---------------------------------------------------------------------------
// midi_timeout_cnt
// Loadable, clearable up-counter with a terminal-count flag. It stops at
// all-ones rather than wrapping, so a stalled count can never alias back to
// a small value.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : force count to zero (highest priority)
//   load       : load load_val
//   load_val   : value taken on load
//   en         : count up by one
//   term       : terminal value to compare against
//   tc         : count equals term
// ---------------------------------------------------------------------------
module midi_timeout_cnt
    import midi_pkg::*;
#(
    parameter int WIDTH = TMO_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count;

    // Counter register: clear beats load beats increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '1)) begin
            count <= count + ONE;
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/midi_msg_ctrl.sv
// ---------------------------------------------------------------------------
// midi_msg_ctrl
// Control FSM for the MIDI receive datapath. Classifies each incoming byte,
// drives the datapath load strobes in the same cycle, tracks running status,
// and flags complete channel messages one cycle later (once the datapath
// registers have captured the final byte). Stalled partial messages are
// abandoned after TIMEOUT_CYC idle cycles.
//   clk, rst_n  : clock, synchronous active-low reset
//   Din         : received byte, valid with Din_rdy
//   Din_rdy     : one-cycle new-byte strobe
//   ld_status   : load Din into the status register (combinational)
//   ld_data1    : load Din into D1 (combinational)
//   ld_data2    : load Din into D2 (combinational)
//   msg_done    : one-cycle pulse, complete message held in the datapath
//   msg_len     : data-byte count of the last flagged message
//   running     : a running status is valid
//   busy        : a partial message is in progress
//   drop_cnt    : saturating count of discarded bytes / aborted messages
// ---------------------------------------------------------------------------
module midi_msg_ctrl
    import midi_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYC = 32'd100000,
    parameter int          DROP_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        Din,
    input  logic              Din_rdy,
    output logic              ld_status,
    output logic              ld_data1,
    output logic              ld_data2,
    output logic              msg_done,
    output logic [1:0]        msg_len,
    output logic              running,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    state_t state;
    logic   need_two;

    logic is_realtime;
    logic is_syscom;
    logic is_status;
    logic is_data;
    logic byte_seen;
    logic tmo_tc;
    logic tmo_fire;

    assign is_realtime = (Din >= REALTIME_MIN);
    assign is_syscom   = (Din >= SYSCOM_MIN) && (Din < REALTIME_MIN);
    assign is_status   = (Din >= STATUS_MIN) && (Din < SYSCOM_MIN);
    assign is_data     = (Din < STATUS_MIN);

    // Real-time bytes are transparent: they neither restart the timeout
    // nor interact with message assembly.
    assign byte_seen = Din_rdy && !is_realtime;

    // Strobes are decoded directly from the incoming byte and current state so
    // the datapath captures Din in the same cycle it is presented. The byte
    // classes are mutually exclusive, so at most one strobe is ever high.
    assign ld_status = rst_n && Din_rdy && is_status;
    assign ld_data1  = rst_n && Din_rdy && is_data && (state == WAIT_D1);
    assign ld_data2  = rst_n && Din_rdy && is_data && (state == WAIT_D2);

    // The timeout counter only runs while a partial message is pending; it
    // sits at zero otherwise so every new message starts a fresh window.
    midi_timeout_cnt #(
        .WIDTH(TMO_W)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (byte_seen || !busy),
        .load    (1'b0),
        .load_val('0),
        .en      (busy),
        .term    (TIMEOUT_CYC),
        .tc      (tmo_tc)
    );

    // A byte arriving in the same cycle as expiry wins: it clears the counter
    // and is processed normally, so no byte is ever lost to a timeout.
    assign tmo_fire = (TIMEOUT_CYC != 32'd0) && busy && tmo_tc && !byte_seen;

    // Message FSM with registered status outputs. msg_done is a single-cycle
    // pulse, so it defaults low and is raised only on the completing byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            need_two <= 1'b0;
            running  <= 1'b0;
            busy     <= 1'b0;
            msg_done <= 1'b0;
            msg_len  <= 2'd0;
            drop_cnt <= '0;
        end else begin
            msg_done <= 1'b0;
            if (Din_rdy && is_syscom) begin
                state   <= IDLE;
                running <= 1'b0;
                busy    <= 1'b0;
            end else if (Din_rdy && is_status) begin
                state    <= WAIT_D1;
                running  <= 1'b1;
                busy     <= 1'b1;
                need_two <= (data_bytes_for(Din[7:4]) == 2'd2);
            end else if (Din_rdy && is_data) begin
                case (state)
                    IDLE: begin
                        if (drop_cnt != '1) begin
                            drop_cnt <= drop_cnt + DROP_ONE;
                        end
                    end
                    WAIT_D1: begin
                        if (need_two) begin
                            state <= WAIT_D2;
                            busy  <= 1'b1;
                        end else begin
                            msg_done <= 1'b1;
                            msg_len  <= 2'd1;
                            busy     <= 1'b0;
                        end
                    end
                    WAIT_D2: begin
                        state    <= WAIT_D1;
                        busy     <= 1'b0;
                        msg_done <= 1'b1;
                        msg_len  <= 2'd2;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (tmo_fire) begin
                state <= WAIT_D1;
                busy  <= 1'b0;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + DROP_ONE;
                end
            end
        end
    end

endmodule
